// File: rtl/id_ex_fwd_stage.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_stage
//
// ID/EX pipeline register with EX-stage operand forwarding.
//
// The register captures the decoded instruction (operands, immediate,
// register numbers, ALU control) on every rising edge unless stalled or
// flushed. The ALU operands are then chosen combinationally from the
// registered register data, the EX/MEM result or the MEM/WB data. That choice
// depends on the registered source register numbers and on the live
// write-back candidates.
//
// Configuration macro:
//   FWD_EN  - when defined, forwarding from EX/MEM and MEM/WB is compiled in.
//             When undefined, the operands come only from registered data or
//             the immediate, fwd_a_o/fwd_b_o read 00 and the exmem_*/memwb_*
//             inputs are ignored.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   stall_i, flush_i        hold the stage / load a bubble (flush wins)
//   valid_i                 ID-side instruction is real
//   rs_data_i, rt_data_i    register-file read data
//   imm_i                   sign-extended immediate
//   rs_addr_i, rt_addr_i,
//   rd_addr_i               source and destination register numbers
//   alu_ctrl_i, alu_src_i   ALU op code, immediate select for operand B
//   reg_write_i             instruction writes rd
//   exmem_regwrite_i, exmem_rd_i, exmem_result_i   EX/MEM write-back candidate
//   memwb_regwrite_i, memwb_rd_i, memwb_data_i     MEM/WB write-back candidate
//   src1_o, src2_o          ALU operands
//   ctrl_o                  ALU op code
//   valid_o, reg_write_o    stage valid, write enable qualified by valid
//   rd_o                    destination register
//   fwd_a_o, fwd_b_o        forward select: 00 register, 10 EX/MEM, 01 MEM/WB
// ---------------------------------------------------------------------------
module id_ex_fwd_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [3:0]        alu_ctrl_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [3:0]        ctrl_o,
  output logic              valid_o,
  output logic              reg_write_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;

  // Registered stage contents
  logic              ex_valid;
  logic              ex_reg_write;
  logic [3:0]        ex_ctrl;
  logic              ex_alu_src;
  logic [REG_AW-1:0] ex_rs_addr;
  logic [REG_AW-1:0] ex_rt_addr;
  logic [REG_AW-1:0] ex_rd_addr;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  // Stage register: reset and flush clear everything, stall holds, otherwise capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= 4'b0000;
      ex_alu_src   <= 1'b0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rd_addr   <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
    end else if (flush_i) begin
      // Flush outranks stall so a squashed instruction never lingers
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_ctrl      <= 4'b0000;
      ex_alu_src   <= 1'b0;
      ex_rs_addr   <= '0;
      ex_rt_addr   <= '0;
      ex_rd_addr   <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
    end else if (!stall_i) begin
      ex_valid     <= valid_i;
      ex_reg_write <= reg_write_i;
      ex_ctrl      <= alu_ctrl_i;
      ex_alu_src   <= alu_src_i;
      ex_rs_addr   <= rs_addr_i;
      ex_rt_addr   <= rt_addr_i;
      ex_rd_addr   <= rd_addr_i;
      ex_rs_data   <= rs_data_i;
      ex_rt_data   <= rt_data_i;
      ex_imm       <= imm_i;
    end
  end

`ifdef FWD_EN
  // Forward-select decode; EX/MEM is checked first so the younger result wins,
  // and register 0 is excluded because its value is hard-wired
  always_comb begin
    fwd_a = SEL_REG;
    fwd_b = SEL_REG;
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs_addr)) begin
      fwd_a = SEL_EXMEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs_addr)) begin
      fwd_a = SEL_MEMWB;
    end else begin
      fwd_a = SEL_REG;
    end
    if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rt_addr)) begin
      fwd_b = SEL_EXMEM;
    end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rt_addr)) begin
      fwd_b = SEL_MEMWB;
    end else begin
      fwd_b = SEL_REG;
    end
  end

  // Operand muxes driven by the forward selects
  always_comb begin
    op_a = ex_rs_data;
    op_b = ex_rt_data;
    case (fwd_a)
      SEL_EXMEM: op_a = exmem_result_i;
      SEL_MEMWB: op_a = memwb_data_i;
      default:   op_a = ex_rs_data;
    endcase
    case (fwd_b)
      SEL_EXMEM: op_b = exmem_result_i;
      SEL_MEMWB: op_b = memwb_data_i;
      default:   op_b = ex_rt_data;
    endcase
  end
`else
  // Forwarding compiled out: operands come straight from the stage register
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exmem_regwrite_i, exmem_rd_i, exmem_result_i,
                               memwb_regwrite_i, memwb_rd_i, memwb_data_i};
  assign fwd_a = SEL_REG;
  assign fwd_b = SEL_REG;
  assign op_a  = ex_rs_data;
  assign op_b  = ex_rt_data;
`endif

  // The immediate replaces operand B; fwd_b is still reported for visibility
  always_comb begin
    if (ex_alu_src) begin
      src2_o = ex_imm;
    end else begin
      src2_o = op_b;
    end
  end

  assign src1_o      = op_a;
  assign ctrl_o      = ex_ctrl;
  assign valid_o     = ex_valid;
  assign reg_write_o = ex_reg_write & ex_valid;
  assign rd_o        = ex_rd_addr;
  assign fwd_a_o     = fwd_a;
  assign fwd_b_o     = fwd_b;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_fwd_stage
//
// Scoreboard bench for id_ex_fwd_stage. Each driven cycle advances a small
// reference model of the stage register. The expected outputs, computed from
// the model and the live write-back inputs, are pushed to a queue. At the
// following falling edge the queue is popped and every output field is
// compared. Forwarding expectations follow FWD_EN, the same as the design.
// ---------------------------------------------------------------------------
module tb_id_ex_fwd_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stall_i, flush_i, valid_i;
  logic [DW-1:0] rs_data_i, rt_data_i, imm_i;
  logic [AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
  logic [3:0]    alu_ctrl_i;
  logic          alu_src_i, reg_write_i;
  logic          exmem_regwrite_i;
  logic [AW-1:0] exmem_rd_i;
  logic [DW-1:0] exmem_result_i;
  logic          memwb_regwrite_i;
  logic [AW-1:0] memwb_rd_i;
  logic [DW-1:0] memwb_data_i;
  logic [DW-1:0] src1_o, src2_o;
  logic [3:0]    ctrl_o;
  logic          valid_o, reg_write_o;
  logic [AW-1:0] rd_o;
  logic [1:0]    fwd_a_o, fwd_b_o;

  id_ex_fwd_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i), .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i),
    .reg_write_i(reg_write_i), .exmem_regwrite_i(exmem_regwrite_i),
    .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
    .memwb_data_i(memwb_data_i), .src1_o(src1_o), .src2_o(src2_o),
    .ctrl_o(ctrl_o), .valid_o(valid_o), .reg_write_o(reg_write_o),
    .rd_o(rd_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model of the registered stage contents
  typedef struct {
    logic          valid, rw, src;
    logic [3:0]    ctrl;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rsd, rtd, imm;
  } mstate_t;

  typedef struct {
    logic [DW-1:0] src1, src2;
    logic [3:0]    ctrl;
    logic          valid, rw;
    logic [AW-1:0] rd;
    logic [1:0]    fa, fb;
  } exp_t;

  mstate_t m;
  exp_t    sb[$];
  int      n_cmp = 0;
  int      n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m.valid = 1'b0; m.rw = 1'b0; m.src = 1'b0; m.ctrl = 4'b0000;
    m.rs = '0; m.rt = '0; m.rd = '0; m.rsd = '0; m.rtd = '0; m.imm = '0;
  endtask

  task automatic model_clock();
    if (flush_i) begin
      model_reset();
    end else if (!stall_i) begin
      m.valid = valid_i; m.rw = reg_write_i; m.src = alu_src_i; m.ctrl = alu_ctrl_i;
      m.rs = rs_addr_i; m.rt = rt_addr_i; m.rd = rd_addr_i;
      m.rsd = rs_data_i; m.rtd = rt_data_i; m.imm = imm_i;
    end
  endtask

  function automatic logic [1:0] sel_for(input logic [AW-1:0] a);
`ifdef FWD_EN
    if (exmem_regwrite_i && exmem_rd_i != 5'd0 && exmem_rd_i == a) return 2'b10;
    if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == a) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] val_for(input logic [1:0] s, input logic [DW-1:0] reg_v);
    if (s == 2'b10) return exmem_result_i;
    if (s == 2'b01) return memwb_data_i;
    return reg_v;
  endfunction

  function automatic exp_t exp_out();
    exp_t e;
    e.fa    = sel_for(m.rs);
    e.fb    = sel_for(m.rt);
    e.src1  = val_for(e.fa, m.rsd);
    e.src2  = m.src ? m.imm : val_for(e.fb, m.rtd);
    e.ctrl  = m.ctrl;
    e.valid = m.valid;
    e.rw    = m.rw & m.valid;
    e.rd    = m.rd;
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check_eq({tag, ".src1"},  64'(src1_o),      64'(e.src1));
    check_eq({tag, ".src2"},  64'(src2_o),      64'(e.src2));
    check_eq({tag, ".ctrl"},  64'(ctrl_o),      64'(e.ctrl));
    check_eq({tag, ".valid"}, 64'(valid_o),     64'(e.valid));
    check_eq({tag, ".rw"},    64'(reg_write_o), 64'(e.rw));
    check_eq({tag, ".rd"},    64'(rd_o),        64'(e.rd));
    check_eq({tag, ".fwd_a"}, 64'(fwd_a_o),     64'(e.fa));
    check_eq({tag, ".fwd_b"}, 64'(fwd_b_o),     64'(e.fb));
  endtask

  // One clock: advance model, push expectation, let the DUT clock, pop and compare
  task automatic step(input string tag);
    exp_t e;
    model_clock();
    sb.push_back(exp_out());
    @(posedge clk_i);
    @(negedge clk_i);
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      compare_all(tag, e);
    end
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z.src1 = '0; z.src2 = '0; z.ctrl = 4'b0000; z.valid = 1'b0; z.rw = 1'b0;
    z.rd = '0; z.fa = 2'b00; z.fb = 2'b00;
    compare_all(tag, z);
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic [DW-1:0] rsd,
                        input logic [DW-1:0] rtd, input logic [3:0] ctrl,
                        input logic src, input logic [DW-1:0] imm, input logic rw);
    valid_i = v; rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
    rs_data_i = rsd; rt_data_i = rtd; alu_ctrl_i = ctrl; alu_src_i = src;
    imm_i = imm; reg_write_i = rw;
  endtask

  task automatic set_wb(input logic ew, input logic [AW-1:0] erd, input logic [DW-1:0] ed,
                        input logic mw, input logic [AW-1:0] mrd, input logic [DW-1:0] md);
    exmem_regwrite_i = ew; exmem_rd_i = erd; exmem_result_i = ed;
    memwb_regwrite_i = mw; memwb_rd_i = mrd; memwb_data_i = md;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops [5];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110; ops[4] = 4'b0111;

    // Reset held low with stall and flush also asserted; reset must win
    rst_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
    set_id(1'b1, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0111, 1'b0, 32'd0, 1'b1);
    set_wb(1'b1, 5'd9, 32'hAAAA_0000, 1'b1, 5'd9, 32'hBBBB_0000);
    model_reset();
    repeat (3) @(negedge clk_i);
    check_zero("reset_hold");
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // First edge after release captures
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 4'b0010, 1'b0, 32'd0, 1'b1);
    step("first_capture");

    // EX/MEM outranks MEM/WB on rs
    set_id(1'b1, 5'd3, 5'd8, 5'd6, 32'h33, 32'h88, 4'b0110, 1'b0, 32'd0, 1'b1);
    set_wb(1'b1, 5'd3, 32'h20, 1'b1, 5'd3, 32'h10);
    step("exmem_prio");

    // MEM/WB alone on rt, EX/MEM on a different register
    set_id(1'b1, 5'd4, 5'd5, 5'd7, 32'h44, 32'h55, 4'b0000, 1'b0, 32'd0, 1'b0);
    set_wb(1'b1, 5'd6, 32'h66, 1'b1, 5'd5, 32'h10);
    step("memwb_only");

    // Register 0 never forwarded; immediate overrides forwarded operand B
    set_id(1'b1, 5'd0, 5'd5, 5'd2, 32'h0, 32'h55, 4'b0010, 1'b1, 32'hFFFF_FFFC, 1'b1);
    set_wb(1'b1, 5'd0, 32'h99, 1'b1, 5'd5, 32'h10);
    step("reg0_imm");

    // Stall for three cycles while ID inputs change; EX/MEM result moves 1 -> 2
    set_id(1'b1, 5'd7, 5'd1, 5'd3, 32'h70, 32'h71, 4'b0001, 1'b0, 32'd0, 1'b1);
    set_wb(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0);
    step("stall_setup");
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b0, 5'($urandom_range(8, 15)), 5'($urandom_range(8, 15)), 5'd9,
             $urandom, $urandom, 4'b0111, 1'b1, $urandom, 1'b0);
      if (i == 1) exmem_result_i = 32'd2;
      step($sformatf("stall%0d", i));
    end
    stall_i = 1'b0;

    // Flush together with stall loads a bubble
    set_id(1'b1, 5'd2, 5'd3, 5'd4, 32'h12, 32'h13, 4'b0110, 1'b0, 32'd0, 1'b1);
    stall_i = 1'b1; flush_i = 1'b1;
    step("flush_stall");
    stall_i = 1'b0; flush_i = 1'b0;

    // Randomised traffic with small register numbers to provoke matches
    for (int i = 0; i < 24; i++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      set_id(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), $urandom, $urandom, ops[$urandom_range(0, 4)],
             1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      step($sformatf("rand%0d", i));
    end
    stall_i = 1'b0; flush_i = 1'b0;

    // Mid-cycle reset clears outputs before the next edge, even with a stall pending
    set_id(1'b1, 5'd3, 5'd2, 5'd5, 32'h33, 32'h22, 4'b0111, 1'b1, 32'h77, 1'b1);
    set_wb(1'b1, 5'd3, 32'h20, 1'b1, 5'd3, 32'h10);
    step("pre_midreset");
    stall_i = 1'b1;
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    model_reset();
    #1 check_zero("mid_reset");
    @(negedge clk_i);
    rst_i = 1'b1; stall_i = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd6, 5'd7, 5'd8, 32'h600, 32'h700, 4'b0001, 1'b0, 32'd0, 1'b1);
    step("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
